if_id_stage: RTL and testbench

Front end of the five-stage MIPS pipeline: PC register, next-PC selection, and the IF/ID pipeline register feeding the decoder and ID/EX register. Stalls on load-use hazards against the instruction in EX and squashes wrong-path instructions when EX resolves a taken branch or jump. Outputs the bubble request that makes the ID/EX stage load zeroed controls.

---
 rtl/mips_pipe_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 19 +
 rtl/if_id_stage.sv | 65 ++++++
 tb/tb_if_id_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// mips_pipe_pkg: shared constants and field helpers for the MIPS pipeline (rev 1.0)
package mips_pipe_pkg;

  localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam logic [4:0] ZERO_REG = 5'd0;

  function automatic logic [4:0] instr_rs(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] instr_rt(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// load_use_detect: flags an ID-stage source that needs the result of a load in EX (rev 1.0)
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_load,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  // rt is compared even for I-types where it is a destination; a spare stall is harmless
  assign hazard = valid && ex_load && (ex_rt != ZERO_REG) &&
                  ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// if_id_stage: PC register, next-PC select and IF/ID register with stall/flush (rev 1.0)
module if_id_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc_4_if,
  output logic [31:0] instr_if,
  output logic        valid_if,
  input  logic        ex_load,
  input  logic [4:0]  ex_rt,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        stall,
  output logic        id_ex_bubble
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic        w_hazard;
  logic        unused_target_lsbs;

  load_use_detect u_load_use_detect (
    .valid   (valid_if),
    .id_rs   (instr_rs(instr_if)),
    .id_rt   (instr_rt(instr_if)),
    .ex_load (ex_load),
    .ex_rt   (ex_rt),
    .hazard  (w_hazard)
  );

  assign w_pc_plus4         = r_pc + 32'd4;
  assign imem_addr          = r_pc;
  assign stall              = w_hazard && !ex_redirect && !rst;
  assign id_ex_bubble       = stall || ex_redirect || rst;
  assign unused_target_lsbs = ^ex_target[1:0];

  // A redirect kills the fetch in flight, so it outranks any load-use hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      instr_if <= NOP_INSTR;
      pc_4_if  <= 32'd0;
      valid_if <= 1'b0;
    end else if (ex_redirect) begin
      r_pc     <= {ex_target[31:2], 2'b00};
      instr_if <= NOP_INSTR;
      pc_4_if  <= 32'd0;
      valid_if <= 1'b0;
    end else if (!w_hazard) begin
      r_pc     <= w_pc_plus4;
      instr_if <= imem_instr;
      pc_4_if  <= w_pc_plus4;
      valid_if <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// tb_if_id_stage: scoreboard bench for the fetch stage and IF/ID register (rev 1.0)
module tb_if_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc_4_if;
  logic [31:0] instr_if;
  logic        valid_if;
  logic        ex_load;
  logic [4:0]  ex_rt;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        stall;
  logic        id_ex_bubble;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc4   = 32'd0;
  logic        m_valid = 1'b0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .pc_4_if      (pc_4_if),
    .instr_if     (instr_if),
    .valid_if     (valid_if),
    .ex_load      (ex_load),
    .ex_rt        (ex_rt),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .stall        (stall),
    .id_ex_bubble (id_ex_bubble)
  );

  // Two words hold "add $2,$5,$4"; everything else is derived from the address
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h3008 || a == 32'h300C) return 32'h00A4_1020;
    return {a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  always_comb imem_instr = imem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic ld, input logic [4:0] rt,
                       input logic redir, input logic [31:0] tgt);
    logic m_hazard;
    logic m_stall;
    exp_t e;
    @(negedge clk);
    rst = r; ex_load = ld; ex_rt = rt; ex_redirect = redir; ex_target = tgt;
    #1;
    m_hazard = m_valid && ld && (rt != 5'd0) &&
               ((rt == m_instr[25:21]) || (rt == m_instr[20:16]));
    m_stall  = m_hazard && !redir && !r;
    check_eq("stall", {31'd0, stall}, {31'd0, m_stall});
    check_eq("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, m_stall || redir || r});
    if (r) begin
      m_pc = 32'h3000; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (redir) begin
      m_pc = {tgt[31:2], 2'b00}; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (!m_hazard) begin
      m_instr = imem_word(m_pc); m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_valid = 1'b1;
    end
    sb_q.push_back('{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("imem_addr", imem_addr, e.pc);
      check_eq("instr_if", instr_if, e.instr);
      check_eq("pc_4_if", pc_4_if, e.pc4);
      check_eq("valid_if", {31'd0, valid_if}, {31'd0, e.valid});
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [4:0]  fld;
    rst = 1'b1; ex_load = 1'b0; ex_rt = 5'd0; ex_redirect = 1'b0; ex_target = 32'd0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check_eq("rst_pc", imem_addr, 32'h3000);
    check_eq("rst_instr", instr_if, 32'h0);

    // Free run
    cycle(0, 0, 0, 0, 0);
    check_eq("run_pc", imem_addr, 32'h3004);
    check_eq("run_pc4", pc_4_if, 32'h3004);
    check_eq("run_instr", instr_if, imem_word(32'h3000));
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check_eq("hz_instr", instr_if, 32'h00A4_1020);

    // Load to $zero never stalls, load to $5 does
    cycle(0, 1, 5'd0, 0, 0);
    check_eq("zero_rt_pc", imem_addr, 32'h3010);
    cycle(0, 1, 5'd5, 0, 0);
    check_eq("stall_hold_pc", imem_addr, 32'h3010);

    // Taken branch at 0x3010
    cycle(0, 0, 0, 1, 32'h3040);
    check_eq("redir_pc", imem_addr, 32'h3040);
    check_eq("redir_valid", {31'd0, valid_if}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check_eq("redir_target_instr", instr_if, imem_word(32'h3040));

    // Hazard and redirect together
    w = imem_word(32'h3040);
    fld = w[20:16];
    cycle(0, 1, fld, 1, 32'h3100);
    check_eq("both_pc", imem_addr, 32'h3100);

    // Misaligned target, back-to-back redirect, PC wrap
    cycle(0, 0, 0, 1, 32'h3043);
    check_eq("misalign_pc", imem_addr, 32'h3040);
    cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 0);
    check_eq("wrap_pc", imem_addr, 32'h0);
    check_eq("wrap_pc4", pc_4_if, 32'h0);
    cycle(0, 0, 0, 0, 0);

    // Reset in the middle of a stall
    w = imem_word(32'h0);
    fld = w[25:21];
    cycle(0, 1, fld, 0, 0);
    check_eq("pre_rst_stall_pc", imem_addr, 32'h4);
    cycle(1, 1, fld, 0, 0);
    check_eq("rst_stall_pc", imem_addr, 32'h3000);
    cycle(0, 0, 0, 0, 0);
    check_eq("post_rst_valid", {31'd0, valid_if}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
